// File: rtl/core_seq.sv
// core_seq: multi-cycle instruction sequencer (fetch/exec/mem/wb) for the NPC core.
// Holds the fetched instruction, gates EXU write enables to the writeback cycle,
// runs the IFU/LSU handshakes, counts retired instructions and stops on
// ebreak or on a bus watchdog timeout.
module core_seq #(
    parameter int ISA_WIDTH = 32,
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ifu_req,
    input  logic                 ifu_rvalid,
    input  logic [ISA_WIDTH-1:0] inst_in,
    output logic [ISA_WIDTH-1:0] inst_out,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 is_ebreak,
    output logic                 lsu_req,
    output logic                 lsu_wen,
    input  logic                 lsu_rvalid,
    input  logic                 pc_w_en_exu,
    input  logic                 gpr_w_en_exu,
    output logic                 pc_w_en,
    output logic                 gpr_w_en,
    output logic                 halt,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] inst_cnt
);

    // Watchdog wide enough to hold TIMEOUT; kept at one bit when disabled.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_e;

    state_e                state_q, state_d;
    logic [ISA_WIDTH-1:0]  inst_q, inst_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  wd_expire;

    // The wait cycle being evaluated is the last one allowed: without rvalid
    // now, the count would reach TIMEOUT.
    assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));

    // Next-state logic: state transitions, instruction latch, retire count, watchdog.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        wd_d    = '0;  // cleared on any transition, so each FETCH/MEM entry starts at 0
        unique case (state_q)
            S_FETCH: begin
                if (ifu_rvalid) begin
                    inst_d  = inst_in;
                    state_d = S_EXEC;
                end else if (wd_expire) begin
                    state_d = S_ERR;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_EXEC: begin
                // ebreak wins over any load/store decode of the same word
                if (is_ebreak)                 state_d = S_HALT;
                else if (is_load || is_store)  state_d = S_MEM;
                else                           state_d = S_WB;
            end
            S_MEM: begin
                if (lsu_rvalid) begin
                    state_d = S_WB;
                end else if (wd_expire) begin
                    state_d = S_ERR;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_WB: begin
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_FETCH;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= S_FETCH;
            inst_q  <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
        end
    end

    assign ifu_req  = (state_q == S_FETCH);
    assign lsu_req  = (state_q == S_MEM);
    assign lsu_wen  = (state_q == S_MEM) && is_store;
    assign pc_w_en  = (state_q == S_WB) && pc_w_en_exu;
    assign gpr_w_en = (state_q == S_WB) && gpr_w_en_exu && !is_store;
    assign halt     = (state_q == S_HALT);
    assign err      = (state_q == S_ERR);
    assign inst_out = inst_q;
    assign inst_cnt = cnt_q;

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: self-checking bench for core_seq (TIMEOUT=8). Expected writeback
// results are queued when an instruction is driven and compared at its WB cycle.
module tb_core_seq;

    localparam int W  = 32;
    localparam int CW = 64;

    localparam logic [W-1:0] ADDI   = 32'h0010_0093;
    localparam logic [W-1:0] LW     = 32'h0000_a103;
    localparam logic [W-1:0] SW     = 32'h0020_a023;
    localparam logic [W-1:0] ADD    = 32'h0020_81b3;
    localparam logic [W-1:0] EBREAK = 32'h0010_0073;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req, ifu_rvalid;
    logic [W-1:0]  inst_in, inst_out;
    logic          is_load, is_store, is_ebreak;
    logic          lsu_req, lsu_wen, lsu_rvalid;
    logic          pc_w_en_exu, gpr_w_en_exu, pc_w_en, gpr_w_en;
    logic          halt, err;
    logic [CW-1:0] inst_cnt;

    typedef struct {
        logic [W-1:0]  inst;
        logic          pc;
        logic          gpr;
        logic [CW-1:0] cnt;
    } sb_item_t;

    sb_item_t      sb_q[$];
    logic [CW-1:0] model_cnt;
    int            total = 0;
    int            bad   = 0;

    core_seq #(.ISA_WIDTH(W), .TIMEOUT(8), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ifu_req     (ifu_req),
        .ifu_rvalid  (ifu_rvalid),
        .inst_in     (inst_in),
        .inst_out    (inst_out),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_ebreak   (is_ebreak),
        .lsu_req     (lsu_req),
        .lsu_wen     (lsu_wen),
        .lsu_rvalid  (lsu_rvalid),
        .pc_w_en_exu (pc_w_en_exu),
        .gpr_w_en_exu(gpr_w_en_exu),
        .pc_w_en     (pc_w_en),
        .gpr_w_en    (gpr_w_en),
        .halt        (halt),
        .err         (err),
        .inst_cnt    (inst_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h @%0t", tag, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifu_rvalid = 1'b0; inst_in = '0; lsu_rvalid = 1'b0;
        is_load = 1'b0; is_store = 1'b0; is_ebreak = 1'b0;
        pc_w_en_exu = 1'b0; gpr_w_en_exu = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        sb_q.delete();
        model_cnt = '0;
        check("rst_ifu_req", 64'(ifu_req), 64'd1);
        check("rst_lsu_req", 64'(lsu_req), 64'd0);
        check("rst_lsu_wen", 64'(lsu_wen), 64'd0);
        check("rst_pc_w_en", 64'(pc_w_en), 64'd0);
        check("rst_gpr_w_en", 64'(gpr_w_en), 64'd0);
        check("rst_halt", 64'(halt), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_inst_out", 64'(inst_out), 64'd0);
        check("rst_inst_cnt", inst_cnt, 64'd0);
    endtask

    // One complete instruction starting in its first FETCH cycle. EXU enables are
    // held for the whole instruction; stray rvalids are driven outside their
    // window to confirm they are ignored.
    task automatic run_inst(input logic [W-1:0] inst, input logic ld, input logic st,
                            input int ifu_wait, input int lsu_wait,
                            input logic pc_exu, input logic gpr_exu);
        sb_item_t it;
        is_load = ld; is_store = st; is_ebreak = 1'b0;
        pc_w_en_exu = pc_exu; gpr_w_en_exu = gpr_exu;
        sb_q.push_back('{inst: inst, pc: pc_exu, gpr: gpr_exu & ~st, cnt: model_cnt + 1});
        for (int i = 0; i <= ifu_wait; i++) begin
            ifu_rvalid = (i == ifu_wait);
            inst_in    = (i == ifu_wait) ? inst : $urandom;
            lsu_rvalid = 1'b1;
            @(negedge clk);
            check("f_ifu_req", 64'(ifu_req), 64'd1);
            check("f_lsu_req", 64'(lsu_req), 64'd0);
            check("f_pc_w_en", 64'(pc_w_en), 64'd0);
            check("f_err", 64'(err), 64'd0);
            step();
        end
        ifu_rvalid = 1'b1; inst_in = $urandom; lsu_rvalid = 1'b1;
        @(negedge clk);
        check("e_inst_out", 64'(inst_out), 64'(inst));
        check("e_ifu_req", 64'(ifu_req), 64'd0);
        check("e_lsu_req", 64'(lsu_req), 64'd0);
        check("e_wen", {62'd0, pc_w_en, gpr_w_en}, 64'd0);
        step();
        if (ld || st) begin
            for (int i = 0; i <= lsu_wait; i++) begin
                lsu_rvalid = (i == lsu_wait);
                ifu_rvalid = 1'b1; inst_in = $urandom;
                @(negedge clk);
                check("m_lsu_req", 64'(lsu_req), 64'd1);
                check("m_lsu_wen", 64'(lsu_wen), 64'(st));
                check("m_wen", {62'd0, pc_w_en, gpr_w_en}, 64'd0);
                check("m_inst_out", 64'(inst_out), 64'(inst));
                check("m_err", 64'(err), 64'd0);
                step();
            end
        end
        ifu_rvalid = 1'b1; inst_in = $urandom; lsu_rvalid = 1'b1;
        @(negedge clk);
        it = sb_q.pop_front();
        check("wb_pc_w_en", 64'(pc_w_en), 64'(it.pc));
        check("wb_gpr_w_en", 64'(gpr_w_en), 64'(it.gpr));
        check("wb_inst_out", 64'(inst_out), 64'(it.inst));
        check("wb_lsu_req", 64'(lsu_req), 64'd0);
        step();
        model_cnt = it.cnt;
        ifu_rvalid = 1'b0; lsu_rvalid = 1'b0;
        check("post_inst_cnt", inst_cnt, model_cnt);
        check("post_ifu_req", 64'(ifu_req), 64'd1);
        check("post_wen", {62'd0, pc_w_en, gpr_w_en}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "time limit");
    end

    initial begin
        do_reset();

        // ALU, zero-wait fetch: F,E,W
        run_inst(ADDI, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        // Load, rvalid on the 3rd MEM cycle
        run_inst(LW, 1'b1, 1'b0, 0, 2, 1'b1, 1'b1);
        // Store with raw GPR enable forced: gated off
        run_inst(SW, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1);
        // Load with rvalid in the 8th wait cycle of both FETCH and MEM
        run_inst(LW, 1'b1, 1'b0, 7, 7, 1'b1, 1'b0);
        // ALU with no PC write, GPR write only
        run_inst(ADD, 1'b0, 1'b0, 2, 0, 1'b0, 1'b1);

        // Reset during MEM with inst_cnt=5
        is_load = 1'b1; is_store = 1'b0; ifu_rvalid = 1'b1; inst_in = LW;
        step();
        ifu_rvalid = 1'b0;
        step();
        @(negedge clk);
        check("mid_lsu_req", 64'(lsu_req), 64'd1);
        check("mid_inst_cnt", inst_cnt, 64'd5);
        rst = 1'b1; lsu_rvalid = 1'b0;
        step();
        rst = 1'b0; is_load = 1'b0;
        @(negedge clk);
        check("mid_rst_ifu_req", 64'(ifu_req), 64'd1);
        check("mid_rst_lsu_req", 64'(lsu_req), 64'd0);
        check("mid_rst_inst_cnt", inst_cnt, 64'd0);
        check("mid_rst_inst_out", 64'(inst_out), 64'd0);

        // Fetch watchdog: 8 wait cycles, err in the 9th
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("wdf_err_low", 64'(err), 64'd0);
            check("wdf_ifu_req", 64'(ifu_req), 64'd1);
            step();
        end
        @(negedge clk);
        check("wdf_err", 64'(err), 64'd1);
        check("wdf_ifu_req_off", 64'(ifu_req), 64'd0);

        // Rerun: rvalid in 8th wait cycle wins; then LSU watchdog
        do_reset();
        for (int i = 0; i < 7; i++) step();
        ifu_rvalid = 1'b1; inst_in = LW; is_load = 1'b1;
        @(negedge clk);
        check("wdr_err_at_8", 64'(err), 64'd0);
        step();
        ifu_rvalid = 1'b0;
        @(negedge clk);
        check("wdr_exec_err", 64'(err), 64'd0);
        check("wdr_exec_ifu_req", 64'(ifu_req), 64'd0);
        check("wdr_exec_inst", 64'(inst_out), 64'(LW));
        step();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("wdm_lsu_req", 64'(lsu_req), 64'd1);
            check("wdm_err_low", 64'(err), 64'd0);
            step();
        end
        pc_w_en_exu = 1'b1; gpr_w_en_exu = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifu_rvalid = i[0]; lsu_rvalid = ~i[0];
            @(negedge clk);
            check("err_sticky", 64'(err), 64'd1);
            check("err_reqs", {62'd0, ifu_req, lsu_req}, 64'd0);
            check("err_wen", {62'd0, pc_w_en, gpr_w_en}, 64'd0);
            step();
        end

        // Ebreak (decoded together with is_load: ebreak has priority)
        do_reset();
        is_ebreak = 1'b1; is_load = 1'b1; ifu_rvalid = 1'b1; inst_in = EBREAK;
        pc_w_en_exu = 1'b1; gpr_w_en_exu = 1'b1;
        step();
        ifu_rvalid = 1'b0;
        @(negedge clk);
        check("eb_exec_halt", 64'(halt), 64'd0);
        step();
        @(negedge clk);
        check("eb_halt", 64'(halt), 64'd1);
        check("eb_lsu_req", 64'(lsu_req), 64'd0);
        for (int i = 0; i < 100; i++) begin
            ifu_rvalid = i[0]; inst_in = $urandom; lsu_rvalid = i[1];
            @(negedge clk);
            check("eb_hold", {60'd0, halt, ifu_req, pc_w_en, gpr_w_en}, 64'h8);
            check("eb_inst_cnt", inst_cnt, 64'd0);
            check("eb_inst_out", 64'(inst_out), 64'(EBREAK));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
